// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and types for the systolic-array result path.
package sa_pkg;
    localparam int DATA_W = 32;
    localparam int N_COLS = 4;
    localparam int ADDR_W = 4;
    localparam int CNT_W = $clog2(N_COLS);
    typedef enum logic {ACCUM, DRAIN} drain_state_t;
    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/result_drain_ctrl_if.sv
// result_drain_ctrl_if: column-beat input and output-buffer store bundle.
interface result_drain_ctrl_if;
    import sa_pkg::*;
    logic col_valid, col_ready, col_last, buf_store_en, busy, done, ovf;
    logic [N_COLS*DATA_W-1:0] col_data;
    logic [ADDR_W-1:0] base_addr, buf_store_addr;
    word_t buf_data;
    modport master(
        output col_valid, col_data, col_last, base_addr,
        input col_ready, buf_data, buf_store_addr, buf_store_en, busy, done, ovf
    );
    modport slave(
        input col_valid, col_data, col_last, base_addr,
        output col_ready, buf_data, buf_store_addr, buf_store_en, busy, done, ovf
    );
endinterface

// File: rtl/acc_lane.sv
// acc_lane: one column accumulator with load/add select and signed-overflow flag.
module acc_lane
    import sa_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  load,
    input  word_t lane,
    output word_t nxt,
    output logic  ovf
);
    word_t acc_q, acc_d, sum;
    always_comb begin
        sum = acc_q + lane;
        acc_d = en ? (load ? lane : sum) : acc_q;
        ovf = !load && acc_q[DATA_W-1] == lane[DATA_W-1] && sum[DATA_W-1] != lane[DATA_W-1];
    end
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
    end
    assign nxt = acc_d;
endmodule

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl: accumulates result rows across K-tiles and drains them,
// one word per cycle, into consecutive output-buffer entries.
module result_drain_ctrl
    import sa_pkg::*;
(
    input logic clk,
    input logic rst,
    result_drain_ctrl_if.slave bus
);
    drain_state_t state_q, state_d;
    logic first_q, first_d, ovf_q, ovf_d, en_q, en_d, done_q, done_d, accept;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    cnt_t cnt_q, cnt_d;
    word_t data_q, data_d;
    word_t acc_nxt [N_COLS];
    logic [N_COLS-1:0] lane_ovf;
    assign accept = bus.col_valid && state_q == ACCUM;
    for (genvar i = 0; i < N_COLS; i++) begin : g_lane
        acc_lane u_lane (
            .clk(clk),
            .rst(rst),
            .en(accept),
            .load(first_q),
            .lane(bus.col_data[i*DATA_W +: DATA_W]),
            .nxt(acc_nxt[i]),
            .ovf(lane_ovf[i])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            first_q <= 1'b1;
            ovf_q <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
            en_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            ovf_q <= ovf_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            en_q <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        ovf_d = ovf_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (state_q == ACCUM) begin
            if (accept) begin
                first_d = 1'b0;
                ovf_d = first_q ? 1'b0 : ovf_q | (|lane_ovf);
                if (bus.col_last) begin
                    state_d = DRAIN;
                    ptr_d = bus.base_addr;
                    cnt_d = '0;
                end
            end
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == cnt_t'(N_COLS-1)) begin
                state_d = ACCUM;
                first_d = 1'b1;
            end
        end
    end
    // Store registers are loaded from next-state values so the first store lands one cycle after the last beat.
    always_comb begin
        en_d = state_d == DRAIN;
        data_d = en_d ? acc_nxt[cnt_d] : data_q;
        addr_d = en_d ? ptr_d + ADDR_W'(cnt_d) : addr_q;
        done_d = en_d && cnt_d == cnt_t'(N_COLS-1);
    end
    assign bus.col_ready = state_q == ACCUM;
    assign bus.busy = state_q == DRAIN;
    assign bus.buf_store_en = en_q;
    assign bus.buf_store_addr = addr_q;
    assign bus.buf_data = data_q;
    assign bus.done = done_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb_result_drain_ctrl: directed and randomized checks against an arithmetic reference model.
module tb_result_drain_ctrl;
    import sa_pkg::*;
    typedef logic [N_COLS*DATA_W-1:0] row_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    result_drain_ctrl_if bus();
    result_drain_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int tests = 0;
    int fails = 0;
    word_t m_acc [N_COLS];
    bit m_first = 1'b1;
    bit m_ovf = 1'b0;
    logic [ADDR_W-1:0] m_base = '0;
    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic row_t pack(input word_t l0, input word_t l1, input word_t l2, input word_t l3);
        return {l3, l2, l1, l0};
    endfunction
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, bus.col_ready, 1);
        chk({tag, "_en"}, bus.buf_store_en, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask
    task automatic chk_reset(input string tag);
        chk_idle(tag);
        chk({tag, "_data"}, bus.buf_data, 0);
        chk({tag, "_addr"}, bus.buf_store_addr, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
    endtask
    // Called at a negedge while the DUT is accumulating; returns at the next negedge.
    task automatic beat(input row_t d, input bit last, input logic [ADDR_W-1:0] base);
        chk("ready_at_beat", bus.col_ready, 1);
        bus.col_valid = 1'b1;
        bus.col_data = d;
        bus.col_last = last;
        bus.base_addr = base;
        if (m_first) m_ovf = 1'b0;
        for (int i = 0; i < N_COLS; i++) begin
            word_t l;
            longint s;
            l = d[i*DATA_W +: DATA_W];
            if (m_first) m_acc[i] = l;
            else begin
                s = longint'(m_acc[i]) + longint'(l);
                if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1'b1;
                m_acc[i] = word_t'(s);
            end
        end
        m_first = 1'b0;
        if (last) m_base = base;
        @(negedge clk);
        if (!last) chk("ovf_after_beat", bus.ovf, m_ovf);
    endtask
    task automatic drain(input bit hold, input row_t nd);
        if (hold) begin
            bus.col_data = nd;
            bus.col_last = 1'b1;
        end else bus.col_valid = 1'b0;
        for (int k = 0; k < N_COLS; k++) begin
            logic [ADDR_W-1:0] a;
            a = m_base + ADDR_W'(k);
            chk("drain_en", bus.buf_store_en, 1);
            chk("drain_addr", bus.buf_store_addr, a);
            chk("drain_data", bus.buf_data, m_acc[k]);
            chk("drain_done", bus.done, k == N_COLS-1);
            chk("drain_busy", bus.busy, 1);
            chk("drain_ready", bus.col_ready, 0);
            chk("drain_ovf", bus.ovf, m_ovf);
            @(negedge clk);
        end
        m_first = 1'b1;
        chk_idle("post_drain");
        chk("post_drain_ovf", bus.ovf, m_ovf);
    endtask
    initial begin
        bus.col_valid = 1'b0;
        bus.col_data = '0;
        bus.col_last = 1'b0;
        bus.base_addr = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("idle");
        // single beat drains raw data
        beat(pack(1, 2, 3, 4), 1'b1, 4'd0);
        drain(1'b0, '0);
        // three-beat accumulation, then a fresh set
        for (int b = 0; b < 3; b++) beat(pack(5, 5, 5, 5), b == 2, 4'd6);
        drain(1'b0, '0);
        beat(pack(1, 1, 1, 1), 1'b1, 4'd9);
        drain(1'b0, '0);
        // address wrap
        beat(pack(7, 8, 9, 10), 1'b1, 4'd14);
        drain(1'b0, '0);
        // signed overflow on lane 0, cleared by the next set's first beat
        beat(pack(32'sh7FFFFFFF, 0, 0, 0), 1'b0, 4'd2);
        beat(pack(1, 0, 0, 0), 1'b1, 4'd2);
        chk("ovf_wrap_data", m_acc[0], 32'h80000000);
        drain(1'b0, '0);
        chk("ovf_sticky", bus.ovf, 1);
        beat(pack(3, 3, 3, 3), 1'b0, 4'd0);
        chk("ovf_cleared", bus.ovf, 0);
        beat(pack(1, 1, 1, 1), 1'b1, 4'd0);
        drain(1'b0, '0);
        // beat held during drain is taken afterwards as the first beat of the next set
        beat(pack(11, 12, 13, 14), 1'b1, 4'd3);
        drain(1'b1, pack(100, 200, 300, 400));
        beat(pack(100, 200, 300, 400), 1'b1, 4'd8);
        drain(1'b0, '0);
        // reset after the second store aborts the drain
        beat(pack(21, 22, 23, 24), 1'b1, 4'd5);
        bus.col_valid = 1'b0;
        chk("abort_store0", bus.buf_store_addr, 5);
        @(negedge clk);
        chk("abort_store1", bus.buf_store_addr, 6);
        chk("abort_en1", bus.buf_store_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        @(negedge clk);
        chk_reset("abort_hold");
        rst = 1'b0;
        m_first = 1'b1;
        m_ovf = 1'b0;
        beat(pack(31, 32, 33, 34), 1'b1, 4'd12);
        drain(1'b0, '0);
        // randomized sets
        for (int s = 0; s < 30; s++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                row_t d;
                for (int i = 0; i < N_COLS; i++)
                    d[i*DATA_W +: DATA_W] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
                beat(d, b == nb-1, ADDR_W'($urandom));
            end
            drain(1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
